// File: rtl/wb_arbiter2.sv
// Round-robin two-master arbiter for pipelined Wishbone; grant is held for the whole bus cycle.
// Latency: one cycle to grant from IDLE, then combinational pass-through; stall while not granted or outstanding is full.
module wb_arbiter2 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_m_i,
  output logic                    m0_stall_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_s_o,

  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_m_i,
  output logic                    m1_stall_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_s_o,

  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_m_o,
  input  logic                    s_stall_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_s_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t             state, state_nxt;
  logic               last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               full;
  logic               accept;
  logic               resp;

  assign full   = (cnt == CNT_W'(MAX_OUTSTANDING));
  assign accept = s_stb_o & ~s_stall_i;
  assign resp   = s_ack_i | s_err_i;

  assign m0_dat_s_o = s_dat_s_i;
  assign m1_dat_s_o = s_dat_s_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Bus muxing: the slave only ever sees the granted master; the other one is held off.
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_adr_o    = '0;
    s_dat_m_o  = '0;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    case (state)
      GRANT0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_cyc_i & m0_stb_i & ~full;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_adr_o    = m0_adr_i;
        s_dat_m_o  = m0_dat_m_i;
        m0_stall_o = s_stall_i | full;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i;
      end
      GRANT1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_cyc_i & m1_stb_i & ~full;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_adr_o    = m1_adr_i;
        s_dat_m_o  = m1_dat_m_i;
        m1_stall_o = s_stall_i | full;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    // Responses with nothing outstanding (e.g. after an abort) never underflow.
    if (accept && !resp)
      cnt_nxt = cnt + CNT_W'(1);
    else if (!accept && resp && cnt != '0)
      cnt_nxt = cnt - CNT_W'(1);
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last ? GRANT0 : GRANT1;
          last_nxt  = ~last;
        end else if (m0_cyc_i) begin
          state_nxt = GRANT0;
          last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = GRANT1;
          last_nxt  = 1'b1;
        end
      end
      GRANT0: begin
        if (!m0_cyc_i) begin
          cnt_nxt = '0;
          if (m1_cyc_i) begin
            state_nxt = GRANT1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GRANT1: begin
        if (!m1_cyc_i) begin
          cnt_nxt = '0;
          if (m0_cyc_i) begin
            state_nxt = GRANT0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: inputs change #1 after the rising edge, outputs checked #1 later.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] m0_adr, m0_datm, m1_adr, m1_datm;
  logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
  logic [31:0] m0_dats, m1_dats;
  logic        s_cyc, s_stb, s_we, s_stall, s_ack, s_err;
  logic [31:0] s_adr, s_datm, s_dats;

  int n_chk  = 0;
  int n_pass = 0;

  // Burst table: master 1 strobe, slave ack and expected count per granted cycle.
  logic [10:0] stb_v = 11'b000_0111_1111;
  logic [10:0] ack_v = 11'b110_1111_0000;
  int          exp_cnt [11] = '{0, 1, 2, 3, 4, 3, 3, 3, 2, 2, 1};

  always #5 clk = ~clk;

  wb_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_m_i(m0_datm), .m0_stall_o(m0_stall), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err), .m0_dat_s_o(m0_dats),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_m_i(m1_datm), .m1_stall_o(m1_stall), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err), .m1_dat_s_o(m1_dats),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_m_o(s_datm), .s_stall_i(s_stall), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_dat_s_i(s_dats)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_sel = 4'hF; m1_sel = 4'h3;
    m0_adr = 32'h100; m1_adr = 32'h200;
    m0_datm = 32'h11; m1_datm = 32'h22;
    {s_stall, s_ack, s_err} = '0;
    s_dats = 32'h0;

    // Reset values
    #3;
    chk("rst_s_cyc", 32'(s_cyc), 0);
    chk("rst_s_stb", 32'(s_stb), 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_s_sel", 32'(s_sel), 0);
    chk("rst_m0_stall", 32'(m0_stall), 1);
    chk("rst_m1_stall", 32'(m1_stall), 1);
    chk("rst_m0_ack", 32'(m0_ack), 0);
    chk("rst_m1_err", 32'(m1_err), 0);
    step();
    rst = 1'b0;

    // Single read from m0
    m0_cyc = 1; m0_stb = 1;
    #1;
    chk("sr_idle_stall", 32'(m0_stall), 1);
    chk("sr_idle_scyc", 32'(s_cyc), 0);
    step();
    chk("sr_grant_scyc", 32'(s_cyc), 1);
    chk("sr_grant_sstb", 32'(s_stb), 1);
    chk("sr_grant_adr", s_adr, 32'h100);
    chk("sr_grant_sel", 32'(s_sel), 32'hF);
    chk("sr_m0_stall", 32'(m0_stall), 0);
    chk("sr_m1_stall", 32'(m1_stall), 1);
    step();
    m0_stb = 0; s_ack = 1; s_dats = 32'hDEADBEEF;
    #1;
    chk("sr_m0_ack", 32'(m0_ack), 1);
    chk("sr_m0_dat", m0_dats, 32'hDEADBEEF);
    chk("sr_m1_ack", 32'(m1_ack), 0);
    chk("sr_cnt1", 32'(dut.cnt), 1);
    step();
    s_ack = 0; m0_cyc = 0;
    #1;
    chk("sr_cnt0", 32'(dut.cnt), 0);
    chk("sr_release_scyc", 32'(s_cyc), 0);
    step();
    chk("sr_idle_again", 32'(m0_stall), 1);

    // Contention and round-robin
    do_reset();
    m0_cyc = 1; m1_cyc = 1; m0_adr = 32'hA0; m1_adr = 32'hB0;
    step();
    chk("rr_first_adr", s_adr, 32'hA0);
    chk("rr_first_m1stall", 32'(m1_stall), 1);
    m0_cyc = 0;
    step();
    chk("rr_handover_scyc", 32'(s_cyc), 1);
    chk("rr_handover_adr", s_adr, 32'hB0);
    chk("rr_handover_m0stall", 32'(m0_stall), 1);
    m0_cyc = 1;
    step();
    chk("rr_no_preempt", s_adr, 32'hB0);
    m1_cyc = 0;
    step();
    chk("rr_back_to_m0", s_adr, 32'hA0);
    m0_cyc = 0;
    step();
    m0_cyc = 1; m1_cyc = 1;
    step();
    chk("rr_idle_contend_m1", s_adr, 32'hB0);
    chk("rr_idle_contend_m0stall", 32'(m0_stall), 1);
    m0_cyc = 0; m1_cyc = 0;
    step();

    // Pipelined burst on m1, slave acks four cycles after accepting
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    step();
    for (int k = 0; k < 11; k++) begin
      m1_stb = stb_v[k]; s_ack = ack_v[k];
      #1;
      chk($sformatf("bu_cnt%0d", k), 32'(dut.cnt), 32'(exp_cnt[k]));
      chk($sformatf("bu_sstb%0d", k), 32'(s_stb), 32'(stb_v[k] && k != 4));
      chk($sformatf("bu_stall%0d", k), 32'(m1_stall), 32'(k == 4));
      chk($sformatf("bu_m1ack%0d", k), 32'(m1_ack), 32'(ack_v[k]));
      chk($sformatf("bu_m0ack%0d", k), 32'(m0_ack), 0);
      step();
    end
    m1_stb = 0; s_ack = 0;
    #1;
    chk("bu_cnt_end", 32'(dut.cnt), 0);
    m1_cyc = 0;
    step();

    // Slave stall then err on m0
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    step();
    s_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("st_m0stall%0d", k), 32'(m0_stall), 1);
      chk($sformatf("st_cnt%0d", k), 32'(dut.cnt), 0);
      step();
    end
    s_stall = 0;
    #1;
    chk("st_release", 32'(m0_stall), 0);
    step();
    m0_stb = 0; s_err = 1;
    #1;
    chk("st_m0_err", 32'(m0_err), 1);
    chk("st_m1_err", 32'(m1_err), 0);
    chk("st_cnt_before", 32'(dut.cnt), 1);
    step();
    s_err = 0;
    #1;
    chk("st_cnt_after", 32'(dut.cnt), 0);

    // Abort with two outstanding while m1 waits
    m0_stb = 1; m1_cyc = 1; m1_adr = 32'h400;
    step();
    step();
    m0_stb = 0;
    #1;
    chk("ab_cnt2", 32'(dut.cnt), 2);
    m0_cyc = 0;
    #1;
    chk("ab_scyc_falls", 32'(s_cyc), 0);
    step();
    chk("ab_to_m1_adr", s_adr, 32'h400);
    chk("ab_to_m1_scyc", 32'(s_cyc), 1);
    chk("ab_cnt_cleared", 32'(dut.cnt), 0);
    m1_cyc = 0;
    step();
    s_ack = 1;
    #1;
    chk("ab_stale_m0", 32'(m0_ack), 0);
    chk("ab_stale_m1", 32'(m1_ack), 0);
    step();
    s_ack = 0;
    #1;
    chk("ab_stale_cnt", 32'(dut.cnt), 0);

    // Reset in the middle of an m1 burst
    m1_cyc = 1; m1_stb = 1;
    step();
    step();
    chk("mr_cnt_pre", 32'(dut.cnt), 1);
    rst = 1;
    #1;
    chk("mr_scyc", 32'(s_cyc), 0);
    chk("mr_sstb", 32'(s_stb), 0);
    chk("mr_sadr", s_adr, 0);
    chk("mr_m1stall", 32'(m1_stall), 1);
    chk("mr_m0stall", 32'(m0_stall), 1);
    chk("mr_cnt", 32'(dut.cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
